// File: rtl/fixed_point_iterative_divider.sv
// Restoring fixed-point divider, one quotient bit per cycle; c = a / b in n.d format.
// val/rdy handshake on both sides; n+d CALC cycles per operation.
module fixed_point_iterative_divider #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter bit sign = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  output logic         recv_rdy,
  input  logic         recv_val,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         send_rdy,
  output logic         send_val,
  output logic [n-1:0] c,
  output logic         div_by_zero
);

  localparam int W  = n + d;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  mag_b_q, mag_b_d;
  logic [n-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic          neg_q, neg_d;
  logic          dbz_q, dbz_d;
  logic          a_neg_q, a_neg_d;

  logic [n:0]    r_shift;
  logic [n-1:0]  r_sub;
  logic          r_ge;
  logic [n-1:0]  mag_a_in, mag_b_in;
  logic [n-1:0]  qmag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag_b_d  = mag_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    a_neg_d  = a_neg_q;
    mag_a_in = (sign && a[n-1]) ? -a : a;
    mag_b_in = (sign && b[n-1]) ? -b : b;
    // Remainder stays below the divisor, so the n-bit wrapped difference is exact.
    r_shift  = {rem_q, quo_q[W-1]};
    r_ge     = (r_shift >= {1'b0, mag_b_q});
    r_sub    = r_shift[n-1:0] - mag_b_q;

    case (state_q)
      IDLE: begin
        if (recv_val) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = W'(mag_a_in) << d;
          mag_b_d = mag_b_in;
          neg_d   = sign & (a[n-1] ^ b[n-1]);
          dbz_d   = (b == '0);
          a_neg_d = sign & a[n-1];
        end
      end
      CALC: begin
        rem_d = r_ge ? r_sub : r_shift[n-1:0];
        quo_d = {quo_q[W-2:0], r_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        cnt_d = '0;
        if (send_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_b_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
      a_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_b_q <= mag_b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      neg_q   <= neg_d;
      dbz_q   <= dbz_d;
      a_neg_q <= a_neg_d;
    end
  end

  // Upper d quotient bits are dropped: overflow wraps like the multiplier's truncation.
  assign qmag        = quo_q[n-1:0];
  assign recv_rdy    = (state_q == IDLE);
  assign send_val    = (state_q == DONE);
  assign div_by_zero = dbz_q;

  always_comb begin
    c = neg_q ? -qmag : qmag;
    if (dbz_q) begin
      if (sign) c = a_neg_q ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      else      c = '1;
    end
  end

endmodule
